// File: rtl/vga_timing_gen.sv
// VGA pixel-timing master: stage-0 counters/decodes drive X_ADDR/Y_ADDR/VGA_DE, stage-1 registers RGB, sync and blank.
// Latency: DAC pins (RGB, HS, VS, BLANK_N) lag X_ADDR/Y_ADDR by exactly one pixel clock, mutually aligned.
// No backpressure: iRed/iGreen/iBlue sampled every cycle; optional colour-bar generator under `VGA_TEST_PATTERN_EN`.
// H_TOTAL and V_TOTAL must both stay <= 2047 so the 11-bit counters cannot overflow.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  input  logic [9:0]  iRed,
  input  logic [9:0]  iGreen,
  input  logic [9:0]  iBlue,
  output logic [10:0] X_ADDR,
  output logic [10:0] Y_ADDR,
  output logic        VGA_DE,
  output logic        FRAME_START,
  output logic [9:0]  VGA_R,
  output logic [9:0]  VGA_G,
  output logic [9:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 11-bit versions of the timing boundaries so every compare is width-matched
  localparam logic [10:0] L_H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] L_V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] L_H_ACTIVE = 11'(H_ACTIVE);
  localparam logic [10:0] L_V_ACTIVE = 11'(V_ACTIVE);
  localparam logic [10:0] L_HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] L_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] L_VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] L_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Stage-0 state
  logic [10:0] r_h_cnt;
  logic [10:0] r_v_cnt;
  logic        r_de;
  logic        r_frame_start;
  logic        r_hs0;
  logic        r_vs0;

  // Stage-1 state
  logic [9:0]  r_red;
  logic [9:0]  r_green;
  logic [9:0]  r_blue;
  logic        r_hs;
  logic        r_vs;
  logic        r_blank_n;

  // Next counter values; decodes are taken from these so they land aligned with the counters
  logic        w_h_wrap;
  logic [10:0] w_h_nxt;
  logic [10:0] w_v_nxt;

  // RGB candidate for stage 1 before DE gating
  logic [9:0]  w_red_sel;
  logic [9:0]  w_green_sel;
  logic [9:0]  w_blue_sel;

  assign w_h_wrap = (r_h_cnt == L_H_LAST);
  assign w_h_nxt  = w_h_wrap ? 11'd0 : (r_h_cnt + 11'd1);
  assign w_v_nxt  = !w_h_wrap              ? r_v_cnt :
                    (r_v_cnt == L_V_LAST)  ? 11'd0   : (r_v_cnt + 11'd1);

  // Stage 0: pixel/line counters plus registered decodes of their next values
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt       <= L_H_LAST;
      r_v_cnt       <= L_V_LAST;
      r_de          <= 1'b0;
      r_frame_start <= 1'b0;
      r_hs0         <= 1'b0;
      r_vs0         <= 1'b0;
    end else begin
      r_h_cnt       <= w_h_nxt;
      r_v_cnt       <= w_v_nxt;
      r_de          <= (w_h_nxt < L_H_ACTIVE) && (w_v_nxt < L_V_ACTIVE);
      r_frame_start <= (w_h_nxt == 11'd0) && (w_v_nxt == 11'd0);
      r_hs0         <= (w_h_nxt >= L_HS_BEG) && (w_h_nxt < L_HS_END);
      r_vs0         <= (w_v_nxt >= L_VS_BEG) && (w_v_nxt < L_VS_END);
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [10:0] L_BAR_LAST = 11'((H_ACTIVE / 8) - 1);

  // Bar index tracks X_ADDR / (H_ACTIVE/8) incrementally, avoiding a divider
  logic [2:0]  r_bar_idx;
  logic [10:0] r_bar_px;

  // Bar counter: restarts with each line, steps the index every H_ACTIVE/8 pixels
  always_ff @(posedge clk) begin
    if (rst || (w_h_nxt == 11'd0)) begin
      r_bar_idx <= 3'd0;
      r_bar_px  <= 11'd0;
    end else if (r_bar_px == L_BAR_LAST) begin
      r_bar_idx <= r_bar_idx + 3'd1;
      r_bar_px  <= 11'd0;
    end else begin
      r_bar_px  <= r_bar_px + 11'd1;
    end
  end

  // Colour source select; bar order white,yellow,cyan,green,magenta,red,blue,black
  // reduces to red=~idx[1], green=~idx[2], blue=~idx[0]
  always_comb begin
    w_red_sel   = iRed;
    w_green_sel = iGreen;
    w_blue_sel  = iBlue;
    if (test_mode) begin
      w_red_sel   = {10{~r_bar_idx[1]}};
      w_green_sel = {10{~r_bar_idx[2]}};
      w_blue_sel  = {10{~r_bar_idx[0]}};
    end
  end
`else
  // Colour source is always the external RGB-select stage
  always_comb begin
    w_red_sel   = iRed;
    w_green_sel = iGreen;
    w_blue_sel  = iBlue;
  end
`endif

  // Stage 1: register DAC colour (blanked outside DE), polarity-mapped syncs and blank
  always_ff @(posedge clk) begin
    if (rst) begin
      r_red     <= 10'd0;
      r_green   <= 10'd0;
      r_blue    <= 10'd0;
      r_hs      <= ~HS_POL;
      r_vs      <= ~VS_POL;
      r_blank_n <= 1'b0;
    end else begin
      r_red     <= r_de ? w_red_sel   : 10'd0;
      r_green   <= r_de ? w_green_sel : 10'd0;
      r_blue    <= r_de ? w_blue_sel  : 10'd0;
      r_hs      <= r_hs0 ? HS_POL : ~HS_POL;
      r_vs      <= r_vs0 ? VS_POL : ~VS_POL;
      r_blank_n <= r_de;
    end
  end

  assign X_ADDR      = r_h_cnt;
  assign Y_ADDR      = r_v_cnt;
  assign VGA_DE      = r_de;
  assign FRAME_START = r_frame_start;
  assign VGA_R       = r_red;
  assign VGA_G       = r_green;
  assign VGA_B       = r_blue;
  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign VGA_BLANK_N = r_blank_n;
  assign VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a shrunken raster so several frames fit in a short run.
// Reference model derives every expectation from the cycle count since reset release.
// Stimulus: random colours, colour-follows-address pattern, mid-frame and random resets.
module tb_vga_timing_gen;

  localparam int HA  = 16;
  localparam int HFP = 2;
  localparam int HSW = 3;
  localparam int HBP = 4;
  localparam int VA  = 6;
  localparam int VFP = 1;
  localparam int VSW = 2;
  localparam int VBP = 3;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam bit HPOL = 1'b0;
  localparam bit VPOL = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  red = '0;
  logic [9:0]  green = '0;
  logic [9:0]  blue = '0;
`ifdef VGA_TEST_PATTERN_EN
  logic        tm = 1'b0;
`endif
  logic [10:0] x_addr;
  logic [10:0] y_addr;
  logic        de;
  logic        fs;
  logic [9:0]  vga_r;
  logic [9:0]  vga_g;
  logic [9:0]  vga_b;
  logic        hs;
  logic        vs;
  logic        blank_n;
  logic        sync_n;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HPOL), .VS_POL(VPOL)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(tm),
`endif
    .iRed(red),
    .iGreen(green),
    .iBlue(blue),
    .X_ADDR(x_addr),
    .Y_ADDR(y_addr),
    .VGA_DE(de),
    .FRAME_START(fs),
    .VGA_R(vga_r),
    .VGA_G(vga_g),
    .VGA_B(vga_b),
    .VGA_HS(hs),
    .VGA_VS(vs),
    .VGA_BLANK_N(blank_n),
    .VGA_SYNC_N(sync_n)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: t = cycles since reset release (-1 while in reset)
  int   t = -1;
  int   e_x, e_y;
  bit   e_de, e_fs, e_hs0, e_vs0;
  logic [9:0] e_r, e_g, e_b;
  bit   e_hs, e_vs, e_bn;

  // What stage 1 registers at the coming edge
  bit   p_de, p_hs0, p_vs0, p_tm;
  int   p_x;
  logic [9:0] p_r, p_g, p_b;

  // Colour bars as {R,G,B}: white,yellow,cyan,green,magenta,red,blue,black
  logic [2:0] bars [8];

  // Aggregate counters over a window
  bit acc = 1'b0;
  int obs_fs, obs_de, obs_hs, obs_vs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp, t);
    end
  endtask

  // One pixel clock: drive inputs, advance the model, check all outputs mid-cycle.
  // mode 0: random colours; 1: R=X, G=Y, B=155; 2: random colours with test_mode=1 (when built in)
  task automatic cycle(input bit r, input int mode);
    rst = r;
    if (mode == 1) begin
      red   = 10'(e_x);
      green = 10'(e_y);
      blue  = 10'h155;
    end else begin
      red   = 10'($urandom);
      green = 10'($urandom);
      blue  = 10'($urandom);
    end
`ifdef VGA_TEST_PATTERN_EN
    tm   = (mode == 2);
    p_tm = tm;
`else
    p_tm = 1'b0;
`endif
    p_de  = e_de;
    p_hs0 = e_hs0;
    p_vs0 = e_vs0;
    p_x   = e_x;
    p_r   = red;
    p_g   = green;
    p_b   = blue;

    @(posedge clk);
    if (r) t = -1;
    else   t = t + 1;

    if (t < 0) begin
      e_x = HT - 1; e_y = VT - 1;
      e_de = 1'b0; e_fs = 1'b0; e_hs0 = 1'b0; e_vs0 = 1'b0;
    end else begin
      e_x   = t % HT;
      e_y   = (t / HT) % VT;
      e_de  = (e_x < HA) && (e_y < VA);
      e_fs  = (e_x == 0) && (e_y == 0);
      e_hs0 = (e_x >= HA + HFP) && (e_x < HA + HFP + HSW);
      e_vs0 = (e_y >= VA + VFP) && (e_y < VA + VFP + VSW);
    end

    if (r) begin
      e_r = '0; e_g = '0; e_b = '0;
      e_hs = ~HPOL; e_vs = ~VPOL; e_bn = 1'b0;
    end else begin
      e_bn = p_de;
      e_hs = p_hs0 ? HPOL : ~HPOL;
      e_vs = p_vs0 ? VPOL : ~VPOL;
      if (!p_de) begin
        e_r = '0; e_g = '0; e_b = '0;
      end else if (p_tm) begin
        logic [2:0] c;
        c   = bars[p_x / (HA / 8)];
        e_r = c[2] ? 10'h3FF : 10'h000;
        e_g = c[1] ? 10'h3FF : 10'h000;
        e_b = c[0] ? 10'h3FF : 10'h000;
      end else begin
        e_r = p_r; e_g = p_g; e_b = p_b;
      end
    end

    @(negedge clk);
    chk("x_addr",  32'(x_addr),  32'(e_x));
    chk("y_addr",  32'(y_addr),  32'(e_y));
    chk("vga_de",  32'(de),      32'(e_de));
    chk("frame_start", 32'(fs),  32'(e_fs));
    chk("vga_r",   32'(vga_r),   32'(e_r));
    chk("vga_g",   32'(vga_g),   32'(e_g));
    chk("vga_b",   32'(vga_b),   32'(e_b));
    chk("vga_hs",  32'(hs),      32'(e_hs));
    chk("vga_vs",  32'(vs),      32'(e_vs));
    chk("blank_n", 32'(blank_n), 32'(e_bn));
    chk("sync_n",  32'(sync_n),  32'(1'b0));
    if (acc) begin
      obs_fs += int'(fs);
      obs_de += int'(de);
      obs_hs += int'(hs == HPOL);
      obs_vs += int'(vs == VPOL);
    end
  endtask

  initial begin
    bars[0] = 3'b111; bars[1] = 3'b110; bars[2] = 3'b011; bars[3] = 3'b010;
    bars[4] = 3'b101; bars[5] = 3'b100; bars[6] = 3'b001; bars[7] = 3'b000;
    e_x = 0; e_y = 0; e_de = 1'b0; e_fs = 1'b0; e_hs0 = 1'b0; e_vs0 = 1'b0;

    @(negedge clk);

    // Reset held 5 cycles: counters parked on the last pixel, pins idle
    repeat (5) cycle(1'b1, 0);

    // Two full frames of random colour from release; first cycle must be (0,0) with DE and FRAME_START
    obs_fs = 0; obs_de = 0; obs_hs = 0; obs_vs = 0;
    acc = 1'b1;
    repeat (2 * HT * VT) cycle(1'b0, 0);
    acc = 1'b0;
    chk("frames_fs_count", 32'(obs_fs), 32'(2));
    chk("frames_de_count", 32'(obs_de), 32'(2 * HA * VA));
    chk("frames_hs_active", 32'(obs_hs), 32'(2 * VT * HSW));
    chk("frames_vs_active", 32'(obs_vs), 32'(2 * VSW * HT));

    // Colour follows the address: VGA_R shows the previous X while unblanked
    repeat (HT * VT) cycle(1'b0, 1);

    // Single-cycle reset mid-frame, then a clean restart
    for (int i = 0; i < HT * VT && !(e_x == 7 && e_y == 3); i++) cycle(1'b0, 0);
    chk("midframe_reached", 32'((e_x == 7) && (e_y == 3)), 32'(1));
    cycle(1'b1, 0);
    repeat (HT * VT + 10) cycle(1'b0, 0);

    // Colour-bar frame (plain random colour when the generator is not built in)
    repeat (HT * VT) cycle(1'b0, 2);

    // Mixed modes with occasional random resets
    repeat (1500) cycle($urandom_range(0, 199) == 0, int'($urandom_range(0, 2)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
